// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter sharing one single-port RAM (sync write, async read).
// Optional `RAM_ARB_CLEAR_EN: zero every RAM word after reset before any request is served.
module ram_arbiter #(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [15:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [15:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [15:0]       ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

  // DEPTH and ADDR_WIDTH describe the same RAM; masking with both keeps a mismatched pair in range.
  localparam logic [15:0] ADDR_MASK = 16'((DEPTH - 1) & ((1 << ADDR_WIDTH) - 1));

  logic              last_b;
  logic              run;
  logic              rd_a_p0;
  logic              rd_b_p0;
  logic [DATA_W-1:0] rdata_a_p1;
  logic [DATA_W-1:0] rdata_b_p1;
  logic              vld_a_p1;
  logic              vld_b_p1;

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clearing;

  assign clearing = (state == ST_CLEAR) && !reset;
  assign run      = (state == ST_RUN) && !reset;
  assign busy     = reset || (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == ADDR_WIDTH'(DEPTH - 1))
        state <= ST_RUN;
    end
  end
`else
  assign run  = !reset;
  assign busy = 1'b0;
`endif

  // Round robin: on a tie the port that was not served last wins.
  assign a_gnt = run && a_req && (!b_req || last_b);
  assign b_gnt = run && b_req && !a_gnt;

  assign rd_a_p0 = a_gnt && !a_we;
  assign rd_b_p0 = b_gnt && !b_we;

  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    if (a_gnt) begin
      ram_address = a_addr & ADDR_MASK;
      ram_in      = a_wdata;
      ram_load    = a_we;
    end else if (b_gnt) begin
      ram_address = b_addr & ADDR_MASK;
      ram_in      = b_wdata;
      ram_load    = b_we;
    end
`ifdef RAM_ARB_CLEAR_EN
    else if (clearing) begin
      ram_address = 16'(clr_cnt);
      ram_load    = 1'b1;
    end
`endif
  end

  // p0 -> p1: grant bookkeeping and read-valid pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b   <= 1'b1;
      vld_a_p1 <= 1'b0;
      vld_b_p1 <= 1'b0;
    end else begin
      if (a_gnt)
        last_b <= 1'b0;
      else if (b_gnt)
        last_b <= 1'b1;
      vld_a_p1 <= rd_a_p0;
      vld_b_p1 <= rd_b_p0;
    end
  end

  // p0 -> p1: capture asynchronous RAM output for the winning reader; held until its next read
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a_p1 <= '0;
      rdata_b_p1 <= '0;
    end else begin
      if (rd_a_p0)
        rdata_a_p1 <= ram_out;
      if (rd_b_p0)
        rdata_b_p1 <= ram_out;
    end
  end

  assign a_rdata  = rdata_a_p1;
  assign a_rvalid = vld_a_p1;
  assign b_rdata  = rdata_b_p1;
  assign b_rvalid = vld_b_p1;

endmodule
